// File: rtl/fdiv_issue.sv
// -----------------------------------------------------------------------------
// fdiv_issue: issue/unpack stage in front of the FPU divider.
//
// Accepts two raw IEEE-754 single operands from the core, unpacks each into
// sign-free class/exponent/significand form, normalizes subnormal significands
// one bit per cycle, then runs the divider enable/ready protocol (with a
// watchdog) and hands the quotient back to the core.
//
// Ports:
//   clk_i, resetn_i           clock, asynchronous active-low reset
//   req_valid_i/req_ready_o   core request handshake (ready only in IDLE)
//   rs1_i, rs2_i, rm_i        dividend, divisor, rounding mode
//   resp_valid_o/resp_ready_i core response handshake
//   result_o, timeout_o       quotient and watchdog-abort flag
//   div_en_o                  divider enable
//   div_rs*_o, div_rm_o       latched raw operands and rounding mode
//   div_rs*_exp_o             signed unbiased exponents (10 bit)
//   div_rs*_sig_o             significands, hidden bit at [23]
//   div_rs*_class_o           one-hot {QNAN,SNAN,INF,NORMAL,SUBNORMAL,ZERO}
//   div_ready_i, div_result_i divider done pulse and result
// -----------------------------------------------------------------------------
module fdiv_issue #(
   parameter int          DIV_TIMEOUT = 63,
   parameter logic [31:0] CANON_NAN   = 32'h7FC00000
) (
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  logic [2:0]  rm_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] result_o,
   output logic        timeout_o,
   output logic        div_en_o,
   output logic [31:0] div_rs1_o,
   output logic [31:0] div_rs2_o,
   output logic [9:0]  div_rs1_exp_o,
   output logic [9:0]  div_rs2_exp_o,
   output logic [23:0] div_rs1_sig_o,
   output logic [23:0] div_rs2_sig_o,
   output logic [5:0]  div_rs1_class_o,
   output logic [5:0]  div_rs2_class_o,
   output logic [2:0]  div_rm_o,
   input  logic        div_ready_i,
   input  logic [31:0] div_result_i
);

   // Watchdog is at least 6 bits and large enough to hold DIV_TIMEOUT.
   localparam int WD_W = ($clog2(DIV_TIMEOUT + 1) > 6) ? $clog2(DIV_TIMEOUT + 1) : 6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UNPACK = 2'd1,
      DIVIDE = 2'd2,
      RESP   = 2'd3
   } state_t;

   typedef struct packed {
      logic [5:0]  cls;
      logic [9:0]  exp;
      logic [23:0] sig;
   } unpacked_t;

   // Split a raw single into class, unbiased exponent and significand.
   // Subnormals start at exp -126 with hidden bit 0; UNPACK normalizes them.
   function automatic unpacked_t unpack_op(input logic [31:0] op);
      unpacked_t  u;
      logic [7:0]  e;
      logic [22:0] m;
      e     = op[30:23];
      m     = op[22:0];
      u.cls = 6'b000000;
      u.exp = 10'd0;
      u.sig = 24'd0;
      if (e == 8'hFF) begin
         u.exp = 10'd128;
         u.sig = {1'b1, m};
         if (m == 23'd0) begin
            u.cls = 6'b001000;
         end else if (m[22]) begin
            u.cls = 6'b100000;
         end else begin
            u.cls = 6'b010000;
         end
      end else if (e == 8'h00) begin
         u.exp = 10'h382;                // -126
         if (m == 23'd0) begin
            u.cls = 6'b000001;
            u.sig = 24'd0;
         end else begin
            u.cls = 6'b000010;
            u.sig = {1'b0, m};
         end
      end else begin
         u.cls = 6'b000100;
         u.exp = {2'b00, e} - 10'd127;
         u.sig = {1'b1, m};
      end
      return u;
   endfunction

   state_t          state_r;
   state_t          state_next_s;
   logic [WD_W-1:0] wd_r;
   logic            need1_s;
   logic            need2_s;
   logic            wd_expired_s;
   unpacked_t       up1_s;
   unpacked_t       up2_s;

   assign up1_s        = unpack_op(rs1_i);
   assign up2_s        = unpack_op(rs2_i);
   // A subnormal still needs a shift until its leading one reaches bit 23.
   assign need1_s      = div_rs1_class_o[1] & ~div_rs1_sig_o[23];
   assign need2_s      = div_rs2_class_o[1] & ~div_rs2_sig_o[23];
   assign wd_expired_s = (wd_r == WD_W'(DIV_TIMEOUT - 1));

   assign req_ready_o  = (state_r == IDLE);
   assign resp_valid_o = (state_r == RESP);
   // Enable drops in the same cycle as the ready pulse so the divider never restarts.
   assign div_en_o     = (state_r == DIVIDE) & ~div_ready_i;

   // State register.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (req_valid_i) begin
               state_next_s = UNPACK;
            end else begin
               state_next_s = IDLE;
            end
         end
         UNPACK: begin
            if (!need1_s && !need2_s) begin
               state_next_s = DIVIDE;
            end else begin
               state_next_s = UNPACK;
            end
         end
         DIVIDE: begin
            if (div_ready_i || wd_expired_s) begin
               state_next_s = RESP;
            end else begin
               state_next_s = DIVIDE;
            end
         end
         RESP: begin
            if (resp_ready_i) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = RESP;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Operand latch, iterative normalization, watchdog and result capture.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         div_rs1_o       <= 32'd0;
         div_rs2_o       <= 32'd0;
         div_rm_o        <= 3'd0;
         div_rs1_exp_o   <= 10'd0;
         div_rs2_exp_o   <= 10'd0;
         div_rs1_sig_o   <= 24'd0;
         div_rs2_sig_o   <= 24'd0;
         div_rs1_class_o <= 6'd0;
         div_rs2_class_o <= 6'd0;
         result_o        <= 32'd0;
         timeout_o       <= 1'b0;
         wd_r            <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid_i) begin
                  div_rs1_o       <= rs1_i;
                  div_rs2_o       <= rs2_i;
                  div_rm_o        <= rm_i;
                  div_rs1_exp_o   <= up1_s.exp;
                  div_rs2_exp_o   <= up2_s.exp;
                  div_rs1_sig_o   <= up1_s.sig;
                  div_rs2_sig_o   <= up2_s.sig;
                  div_rs1_class_o <= up1_s.cls;
                  div_rs2_class_o <= up2_s.cls;
               end
            end
            UNPACK: begin
               wd_r <= '0;
               if (need1_s) begin
                  div_rs1_sig_o <= {div_rs1_sig_o[22:0], 1'b0};
                  div_rs1_exp_o <= div_rs1_exp_o - 10'd1;
               end
               if (need2_s) begin
                  div_rs2_sig_o <= {div_rs2_sig_o[22:0], 1'b0};
                  div_rs2_exp_o <= div_rs2_exp_o - 10'd1;
               end
            end
            DIVIDE: begin
               if (div_ready_i) begin
                  result_o  <= div_result_i;
                  timeout_o <= 1'b0;
               end else if (wd_expired_s) begin
                  result_o  <= CANON_NAN;
                  timeout_o <= 1'b1;
                  wd_r      <= WD_W'(DIV_TIMEOUT);
               end else begin
                  wd_r <= wd_r + {{(WD_W-1){1'b0}}, 1'b1};
               end
            end
            RESP: begin
               wd_r <= wd_r;
            end
            default: begin
               wd_r <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fdiv_issue.sv
// -----------------------------------------------------------------------------
// tb_fdiv_issue: directed bench for fdiv_issue. Expected responses are queued
// at issue time; a monitor pops and compares on every response handshake.
// A stub divider answers after a programmable latency or never.
// -----------------------------------------------------------------------------
module tb_fdiv_issue;

   logic        clk_i = 1'b0;
   logic        resetn_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic [2:0]  rm_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [31:0] result_o;
   logic        timeout_o;
   logic        div_en_o;
   logic [31:0] div_rs1_o;
   logic [31:0] div_rs2_o;
   logic [9:0]  div_rs1_exp_o;
   logic [9:0]  div_rs2_exp_o;
   logic [23:0] div_rs1_sig_o;
   logic [23:0] div_rs2_sig_o;
   logic [5:0]  div_rs1_class_o;
   logic [5:0]  div_rs2_class_o;
   logic [2:0]  div_rm_o;
   logic        div_ready_i;
   logic [31:0] div_result_i;

   fdiv_issue dut (
      .clk_i(clk_i), .resetn_i(resetn_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rm_i(rm_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .result_o(result_o), .timeout_o(timeout_o),
      .div_en_o(div_en_o),
      .div_rs1_o(div_rs1_o), .div_rs2_o(div_rs2_o),
      .div_rs1_exp_o(div_rs1_exp_o), .div_rs2_exp_o(div_rs2_exp_o),
      .div_rs1_sig_o(div_rs1_sig_o), .div_rs2_sig_o(div_rs2_sig_o),
      .div_rs1_class_o(div_rs1_class_o), .div_rs2_class_o(div_rs2_class_o),
      .div_rm_o(div_rm_o),
      .div_ready_i(div_ready_i), .div_result_i(div_result_i)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [31:0] res;
      logic        to;
   } exp_t;
   exp_t sb_q[$];
   exp_t mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Stub divider: drives ready on negedge, lat enable cycles after start.
   int          lat    = 3;
   bit          hang   = 1'b0;
   logic [31:0] stub_result = 32'd0;
   int          scnt   = 0;
   int          en_cnt = 0;

   always @(negedge clk_i) begin
      if (!resetn_i) begin
         div_ready_i = 1'b0;
         scnt        = 0;
      end else if (div_ready_i) begin
         div_ready_i = 1'b0;
         scnt        = 0;
      end else if (div_en_o) begin
         en_cnt++;
         if (!hang) begin
            if (scnt == lat - 1) begin
               div_ready_i  = 1'b1;
               div_result_i = stub_result;
               #1;
               check("en_drop_with_ready", {31'd0, div_en_o}, 32'd0);
            end else begin
               scnt++;
            end
         end
      end
   end

   // Monitor: compare every accepted response against the scoreboard.
   always @(negedge clk_i) begin
      if (resetn_i && resp_valid_o && resp_ready_i) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp: got %h expected none", result_o);
         end else begin
            mon_e = sb_q.pop_front();
            check("result", result_o, mon_e.res);
            check("timeout", {31'd0, timeout_o}, {31'd0, mon_e.to});
         end
      end
   end

   // Issue one request and return the number of cycles spent in UNPACK.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                        input logic [31:0] res, input logic to, input bit expect_resp,
                        output int ucyc);
      int w;
      w = 0;
      while (!req_ready_o && w < 200) begin
         @(posedge clk_i); #1; w++;
      end
      check("req_ready_before_issue", {31'd0, req_ready_o}, 32'd1);
      if (expect_resp) sb_q.push_back(exp_t'{res, to});
      stub_result = res;
      en_cnt      = 0;
      rs1_i       = a;
      rs2_i       = b;
      rm_i        = rm;
      req_valid_i = 1'b1;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      ucyc = 0;
      while (!div_en_o && ucyc < 100) begin
         @(posedge clk_i); #1; ucyc++;
      end
      if (!div_en_o) begin
         n_checks++;
         n_fail++;
         $display("FAIL divide_entry: got no enable expected enable");
      end
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (!req_ready_o && w < 300) begin
         @(posedge clk_i); #1; w++;
      end
      check("return_to_idle", {31'd0, req_ready_o}, 32'd1);
   endtask

   int uc;
   int n;

   initial begin
      resetn_i     = 1'b0;
      req_valid_i  = 1'b0;
      rs1_i        = 32'd0;
      rs2_i        = 32'd0;
      rm_i         = 3'd0;
      resp_ready_i = 1'b1;
      div_ready_i  = 1'b0;
      div_result_i = 32'd0;
      #12;
      check("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
      check("rst_div_en", {31'd0, div_en_o}, 32'd0);
      check("rst_result", result_o, 32'd0);
      @(negedge clk_i);
      resetn_i = 1'b1;
      @(posedge clk_i); #1;

      // 6.0 / 2.0 = 3.0
      lat = 3;
      issue(32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 1'b0, 1'b1, uc);
      check("t1_unpack_cycles", uc, 32'd1);
      check("t1_exp1", {22'd0, div_rs1_exp_o}, 32'h002);
      check("t1_exp2", {22'd0, div_rs2_exp_o}, 32'h001);
      check("t1_sig1", {8'd0, div_rs1_sig_o}, 32'h00C00000);
      check("t1_sig2", {8'd0, div_rs2_sig_o}, 32'h00800000);
      check("t1_class1", {26'd0, div_rs1_class_o}, 32'h04);
      check("t1_rs1", div_rs1_o, 32'h40C00000);
      wait_idle();
      check("t1_enable_cycles", en_cnt, 32'd3);

      // Smallest subnormal: 23 shifts, exp -149
      lat = 2;
      issue(32'h00000001, 32'h3F800000, 3'd0, 32'h00000001, 1'b0, 1'b1, uc);
      check("t2_unpack_cycles", uc, 32'd24);
      check("t2_exp1", {22'd0, div_rs1_exp_o}, 32'h36B);
      check("t2_sig1", {8'd0, div_rs1_sig_o}, 32'h00800000);
      check("t2_class1", {26'd0, div_rs1_class_o}, 32'h02);
      check("t2_exp2", {22'd0, div_rs2_exp_o}, 32'h000);
      wait_idle();

      // QNaN / -Inf
      lat = 1;
      issue(32'h7FC00000, 32'hFF800000, 3'd3, 32'h7FC00000, 1'b0, 1'b1, uc);
      check("t3_class1", {26'd0, div_rs1_class_o}, 32'h20);
      check("t3_class2", {26'd0, div_rs2_class_o}, 32'h08);
      check("t3_exp1", {22'd0, div_rs1_exp_o}, 32'h080);
      check("t3_exp2", {22'd0, div_rs2_exp_o}, 32'h080);
      check("t3_sig1", {8'd0, div_rs1_sig_o}, 32'h00C00000);
      check("t3_rm", {29'd0, div_rm_o}, 32'd3);
      wait_idle();

      // +0 / -0
      lat = 4;
      issue(32'h00000000, 32'h80000000, 3'd1, 32'h7FC00000, 1'b0, 1'b1, uc);
      check("t4_unpack_cycles", uc, 32'd1);
      check("t4_class1", {26'd0, div_rs1_class_o}, 32'h01);
      check("t4_exp1", {22'd0, div_rs1_exp_o}, 32'h382);
      check("t4_sig2", {8'd0, div_rs2_sig_o}, 32'h0);
      wait_idle();

      // Watchdog: divider never answers
      hang = 1'b1;
      issue(32'h3F800000, 32'h40000000, 3'd0, 32'h7FC00000, 1'b1, 1'b1, uc);
      n = 0;
      while (div_en_o && n < 200) begin
         n++;
         @(posedge clk_i); #1;
      end
      check("t5_divide_cycles", n, 32'd63);
      check("t5_resp_valid", {31'd0, resp_valid_o}, 32'd1);
      check("t5_timeout", {31'd0, timeout_o}, 32'd1);
      check("t5_div_en", {31'd0, div_en_o}, 32'd0);
      hang = 1'b0;
      wait_idle();

      // Response back-pressure for 10 cycles
      lat = 2;
      resp_ready_i = 1'b0;
      issue(32'h3F800000, 32'h3F800000, 3'd0, 32'h3F800000, 1'b0, 1'b1, uc);
      n = 0;
      while (!resp_valid_o && n < 100) begin
         @(posedge clk_i); #1; n++;
      end
      repeat (10) begin
         @(posedge clk_i); #1;
      end
      check("t6_held_result", result_o, 32'h3F800000);
      check("t6_held_valid", {31'd0, resp_valid_o}, 32'd1);
      check("t6_req_ready", {31'd0, req_ready_o}, 32'd0);
      resp_ready_i = 1'b1;
      wait_idle();

      // Reset mid-DIVIDE: in-flight op is dropped without a response
      hang = 1'b1;
      issue(32'h40400000, 32'h3F800000, 3'd0, 32'h0, 1'b0, 1'b0, uc);
      repeat (5) begin
         @(posedge clk_i); #1;
      end
      resetn_i = 1'b0;
      #1;
      check("t7_div_en", {31'd0, div_en_o}, 32'd0);
      check("t7_req_ready", {31'd0, req_ready_o}, 32'd1);
      check("t7_resp_valid", {31'd0, resp_valid_o}, 32'd0);
      check("t7_rs1", div_rs1_o, 32'd0);
      check("t7_class1", {26'd0, div_rs1_class_o}, 32'd0);
      @(negedge clk_i);
      resetn_i = 1'b1;
      hang = 1'b0;
      @(posedge clk_i); #1;

      // 10.0 / 5.0 = 2.0
      lat = 3;
      issue(32'h41200000, 32'h40A00000, 3'd2, 32'h40000000, 1'b0, 1'b1, uc);
      check("t8_exp1", {22'd0, div_rs1_exp_o}, 32'h003);
      check("t8_exp2", {22'd0, div_rs2_exp_o}, 32'h002);
      check("t8_sig2", {8'd0, div_rs2_sig_o}, 32'h00A00000);
      wait_idle();

      repeat (3) begin
         @(posedge clk_i); #1;
      end
      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

endmodule

// File: doc/fdiv_issue.md
Name: fdiv_issue

Overview:
- Upstream issue/unpack stage for the FPU divider.
- Accepts raw IEEE-754 single operands from the core over a valid/ready handshake and unpacks them into sign, unbiased exponent, significand and class.
- Normalizes subnormal significands iteratively, then sequences the divider's enable/ready protocol and returns its result to the core over a second valid/ready handshake.

Parameters:
- DIV_TIMEOUT, 63, cycles in DIVIDE without div_ready_i before the watchdog aborts the operation.
- CANON_NAN, 32'h7FC00000, result returned on a watchdog abort.

Ports:
- clk_i  in  1  clock, all state on posedge.
- resetn_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  core presents an operation.
- req_ready_o  out  1  block can accept; high only in IDLE.
- rs1_i  in  32  dividend, raw IEEE single.
- rs2_i  in  32  divisor, raw IEEE single.
- rm_i  in  3  rounding mode.
- resp_valid_o  out  1  result_o valid.
- resp_ready_i  in  1  core accepts the result.
- result_o  out  32  quotient.
- timeout_o  out  1  result is a watchdog abort; qualified by resp_valid_o.
- div_en_o  out  1  divider enable.
- div_rs1_o / div_rs2_o  out  32  latched raw operands.
- div_rs1_exp_o / div_rs2_exp_o  out  10  signed unbiased exponents.
- div_rs1_sig_o / div_rs2_sig_o  out  24  significands, hidden bit at [23].
- div_rs1_class_o / div_rs2_class_o  out  6  one-hot class, bits [5:0] = QNAN, SNAN, INF, NORMAL, SUBNORMAL, ZERO.
- div_rm_o  out  3  latched rounding mode.
- div_ready_i  in  1  divider done pulse; changes on negedge.
- div_result_i  in  32  divider output; valid while div_ready_i is high.

Behaviour:
- Reset (async, resetn_i low): state=IDLE; all outputs 0 except req_ready_o, which is 1. Reset is honoured in any state and drops div_en_o immediately. Any in-flight operation is discarded, with no response.
- States: IDLE, UNPACK, DIVIDE, RESP.
- IDLE:
  - On req_valid_i & req_ready_o, latch rs1_i, rs2_i and rm_i, and compute the unpack for each operand:
    - exp field 0xFF, mant 0: INF, exp=128, sig={1,mant}.
    - exp field 0xFF, mant≠0: QNAN if mant[22] else SNAN; exp=128, sig={1,mant}.
    - exp field 0, mant 0: ZERO, exp=-126, sig=0.
    - exp field 0, mant≠0: SUBNORMAL, exp=-126, sig={0,mant}.
    - otherwise: NORMAL, exp=E-127, sig={1,mant}.
  - Next state is UNPACK.
- UNPACK:
  - Each cycle, independently for each operand: if class is SUBNORMAL and sig[23]=0, shift sig left by 1 and decrement exp by 1.
  - When neither operand needs a shift, go to DIVIDE.
  - This takes 1 cycle for normal operands and up to 23 extra cycles; 0x00000001 ends at exp=-149, sig=0x800000.
  - The class field stays SUBNORMAL after normalization.
- DIVIDE:
  - div_en_o = (state==DIVIDE) & ~div_ready_i, combinational.
  - Enable must fall in the same cycle the ready pulse arrives so the divider does not restart.
  - All div_* operand outputs stay stable for the whole state.
  - On a posedge with div_ready_i=1: result_o <= div_result_i, timeout_o <= 0, go to RESP.
  - A watchdog counter clears on DIVIDE entry. If it reaches DIV_TIMEOUT with no ready: result_o <= CANON_NAN, timeout_o <= 1, div_en_o low, go to RESP.
- RESP:
  - resp_valid_o=1; result_o and timeout_o are held stable while resp_ready_i is low.
  - On resp_ready_i, go to IDLE and drop resp_valid_o in the next cycle.
  - No new request is accepted until IDLE; there is no request/response overlap.
- req_valid_i outside IDLE is ignored; the core holds it until req_ready_o is high.
- A div_ready_i outside DIVIDE is ignored.
- The watchdog counter is 6 bits minimum and does not wrap; it saturates at DIV_TIMEOUT.
- Minimum latency from request accept to resp_valid_o is 2 + divider latency cycles.

Test Plan:
- 0x40C00000 / 0x40000000, rm=0, behavioural divider model: UNPACK lasts 1 cycle, div exps 2 and 1, sigs 0xC00000 and 0x800000 → result_o=0x40400000, timeout_o=0.
- rs1=0x00000001, rs2=0x3F800000: UNPACK lasts 24 cycles → div_rs1_exp_o=-149, div_rs1_sig_o=0x800000, class 6'b000010, then DIVIDE.
- rs1=0x7FC00000, rs2=0xFF800000 → classes 6'b100000 and 6'b001000, exps 128.
- Ready pulse: div_en_o drops combinationally with div_ready_i, no second enable cycle, and result is captured on the same posedge.
- Stub divider that never asserts ready → after 63 DIVIDE cycles, result_o=0x7FC00000, timeout_o=1, div_en_o=0.
- resp_ready_i held low for 10 cycles: result held and req_ready_o=0. Then assert resetn_i low mid-DIVIDE: all outputs 0 immediately, req_ready_o=1, and a fresh request completes correctly.
